// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall requests and branch resolution going into the
// controller, per-stage hold, flush, redirect and statistics coming out.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_exe;
  logic        stallreq_mem;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [5:0]  stall;
  logic        flush;
  logic        pc_redirect_en;
  logic [31:0] pc_redirect_addr;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  // Pipeline side: raises requests, consumes the control outputs.
  modport master (
    output stallreq_if, stallreq_id, stallreq_exe, stallreq_mem,
    output branch_en, branch_target,
    input  stall, flush, pc_redirect_en, pc_redirect_addr,
    input  stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_exe, stallreq_mem,
    input  branch_en, branch_target,
    output stall, flush, pc_redirect_en, pc_redirect_addr,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for a 6-stage in-order pipeline.
// Stall vector bit order: 0 PC, 1 IF, 2 ID, 3 EXE, 4 MEM, 5 WB (1 = hold).
// A taken branch resolved in EXE is latched and held as a pending redirect;
// while pending, PC/IF/ID are frozen so that no wrong-path instruction gets
// into EXE. The redirect fires (PC load + flush) on the first cycle in which
// fetch, execute and memory are all free. Stall and flush statistics are
// kept in saturating counters.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_IF   = 6'b000011;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EXE  = 6'b001111;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;
  localparam logic [5:0]  HOLD_FRONT = 6'b000111;
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] redirect_addr_q;
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  logic [5:0]  base_stall;
  logic [5:0]  stall_out;
  logic        back_busy;
  logic        accept_branch;
  logic        redirect_now;

  // Base stall pattern: the furthest-downstream requester wins, and every
  // stage upstream of it is held too.
  always_comb begin
    base_stall = STALL_NONE;
    if (bus.stallreq_mem) begin
      base_stall = STALL_MEM;
    end else if (bus.stallreq_exe) begin
      base_stall = STALL_EXE;
    end else if (bus.stallreq_id) begin
      base_stall = STALL_ID;
    end else if (bus.stallreq_if) begin
      base_stall = STALL_IF;
    end
  end

  // Branch acceptance and redirect qualification. A branch seen while EXE or
  // MEM is busy is ignored because EXE keeps holding it and re-presents it;
  // stallreq_id is irrelevant to the redirect since it comes from a
  // wrong-path instruction.
  always_comb begin
    back_busy     = bus.stallreq_exe | bus.stallreq_mem;
    accept_branch = 1'b0;
    redirect_now  = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        accept_branch = bus.branch_en & ~back_busy;
      end else begin
        redirect_now = ~bus.stallreq_if & ~back_busy;
      end
    end
  end

  // Driven stall vector: pending redirects freeze PC/IF/ID so ID/EXE gets a
  // bubble; everything is released while reset is asserted.
  always_comb begin
    stall_out = STALL_NONE;
    if (!rst) begin
      if (state == PENDING) begin
        stall_out = base_stall | HOLD_FRONT;
      end else begin
        stall_out = base_stall;
      end
    end
  end

  // Redirect FSM: latches the branch target on acceptance and returns to
  // IDLE once the redirect has been issued; reset drops any pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      redirect_addr_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_branch) begin
            redirect_addr_q <= bus.branch_target;
            state           <= PENDING;
          end
        end
        PENDING: begin
          if (redirect_now) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'h0;
    end else if (stall_out[0] && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  // Saturating count of issued redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_count_q <= 32'h0;
    end else if (redirect_now && (flush_count_q != CNT_MAX)) begin
      flush_count_q <= flush_count_q + 32'd1;
    end
  end

  // Output drive: flush and PC load are same-cycle pulses of the redirect.
  always_comb begin
    bus.stall            = stall_out;
    bus.flush            = redirect_now;
    bus.pc_redirect_en   = redirect_now;
    bus.pc_redirect_addr = redirect_addr_q;
    bus.stall_cycles     = stall_cycles_q;
    bus.flush_count      = flush_count_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic. A
// driver applies one cycle of inputs at a time and pushes the reference
// model's expected outputs into a queue; a monitor pops and compares on the
// falling edge.
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        pc_en;
    logic [31:0] addr;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;

  // Reference model state: whether a redirect is owed, where to, and counters.
  bit          m_pend;
  logic [31:0] m_addr;
  logic [31:0] m_sc;
  logic [31:0] m_fc;

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // One cycle of stimulus: drive inputs after the rising edge, record the
  // expected same-cycle outputs, then advance the model past the next edge.
  task automatic applyStimulus(input bit r, input bit s_if, input bit s_id,
                               input bit s_exe, input bit s_mem,
                               input bit br, input logic [31:0] tgt);
    exp_t e;
    int   depth;
    bit   redirect;
    @(posedge clk);
    #1;
    rst               = r;
    bus.stallreq_if   = s_if;
    bus.stallreq_id   = s_id;
    bus.stallreq_exe  = s_exe;
    bus.stallreq_mem  = s_mem;
    bus.branch_en     = br;
    bus.branch_target = tgt;

    depth = s_mem ? 5 : s_exe ? 4 : s_id ? 3 : s_if ? 2 : 0;
    redirect = !r && m_pend && !s_if && !s_exe && !s_mem;
    e.stall = r ? 6'd0 : 6'((1 << depth) - 1) | (m_pend ? 6'd7 : 6'd0);
    e.flush = redirect;
    e.pc_en = redirect;
    e.addr  = m_addr;
    e.sc    = m_sc;
    e.fc    = m_fc;
    exp_q.push_back(e);

    if (r) begin
      m_pend = 1'b0;
      m_addr = 32'h0;
      m_sc   = 32'h0;
      m_fc   = 32'h0;
    end else begin
      if (e.stall[0]) m_sc = sat_inc(m_sc);
      if (redirect) m_fc = sat_inc(m_fc);
      if (m_pend) begin
        if (redirect) m_pend = 1'b0;
      end else if (br && !s_exe && !s_mem) begin
        m_pend = 1'b1;
        m_addr = tgt;
      end
    end
  endtask

  // Monitor: every falling edge with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("stall", 32'(bus.stall), 32'(e.stall));
        checkOutput("flush", 32'(bus.flush), 32'(e.flush));
        checkOutput("pc_redirect_en", 32'(bus.pc_redirect_en), 32'(e.pc_en));
        checkOutput("pc_redirect_addr", bus.pc_redirect_addr, e.addr);
        checkOutput("stall_cycles", bus.stall_cycles, e.sc);
        checkOutput("flush_count", bus.flush_count, e.fc);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst               = 1'b1;
    bus.stallreq_if   = 1'b0;
    bus.stallreq_id   = 1'b0;
    bus.stallreq_exe  = 1'b0;
    bus.stallreq_mem  = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_target = 32'h0;
    m_pend = 1'b0;
    m_addr = 32'h0;
    m_sc   = 32'h0;
    m_fc   = 32'h0;
    repeat (2) @(posedge clk);

    // Reset holds outputs low even with every request raised.
    applyStimulus(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF);

    // Stall priority patterns.
    applyStimulus(0, 1, 0, 0, 1, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 0, 0, 32'h0);

    // Clean branch with immediate redirect on the next cycle.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_1040);
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

    // Delayed redirect: fetch busy for three cycles after acceptance.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_2000);
    applyStimulus(0, 1, 0, 0, 0, 1, 32'h0000_3000);
    applyStimulus(0, 1, 1, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

    // Branch during a MEM stall is ignored, then accepted once MEM frees up.
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_4000);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'h0000_4000);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_4000);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

    // Reset while a redirect is pending discards it.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_5000);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

    // Saturation of stall_cycles from a preloaded value.
    @(negedge clk);
    #1;
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles_q;
    m_sc = 32'hFFFF_FFFD;
    repeat (5) applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 2) == 0),
                    $urandom());
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset (`RstEnable` = 1).
REQ-003 SHALL have port stallreq_if, input, 1 bit: fetch not ready.
REQ-004 SHALL have port stallreq_id, input, 1 bit: decode hazard (load-use).
REQ-005 SHALL have port stallreq_exe, input, 1 bit: multi-cycle execute busy.
REQ-006 SHALL have port stallreq_mem, input, 1 bit: memory access busy.
REQ-007 SHALL have port branch_en, input, 1 bit: EXE resolved a taken or mispredicted branch this cycle.
REQ-008 SHALL have port branch_target, input, 32 bits: redirect address qualified by branch_en.
REQ-009 SHALL have port stall, output, 6 bits: per-stage hold; bit 0 PC, 1 IF, 2 ID, 3 EXE, 4 MEM, 5 WB; `STOP` = 1, `NOSTOP` = 0.
REQ-010 SHALL have port flush, output, 1 bit: clear IF/ID and ID/EXE to NOP this cycle.
REQ-011 SHALL have port pc_redirect_en, output, 1 bit: load the PC from pc_redirect_addr.
REQ-012 SHALL have port pc_redirect_addr, output, 32 bits: latched branch target.
REQ-013 SHALL have port stall_cycles, output, 32 bits: count of cycles with stall[0] = `STOP`.
REQ-014 SHALL have port flush_count, output, 32 bits: count of issued redirects.

Function
REQ-015 SHALL derive the base stall pattern combinationally, with highest stage winning: mem -> 6'b011111; else exe -> 6'b001111; else id -> 6'b000111; else if -> 6'b000011; else 6'b000000.
REQ-016 SHALL implement an FSM with two states, IDLE and PENDING, held in a register.
REQ-017 SHALL, in IDLE, accept branch_en only when stallreq_exe = 0 and stallreq_mem = 0; on acceptance it latches branch_target into pc_redirect_addr and moves to PENDING at the next edge.
REQ-018 SHALL, in IDLE, ignore branch_en while stallreq_exe or stallreq_mem = 1, because EXE holds the branch and re-presents it.
REQ-019 SHALL, in PENDING, drive stall = base pattern OR 6'b000111, so that no wrong-path instruction enters EXE (ID/EXE receives a bubble because stall[2] = 1 and stall[3] = 0).
REQ-020 SHALL define the redirect condition in PENDING as stallreq_if = 0, stallreq_exe = 0 and stallreq_mem = 0; stallreq_id is ignored because it belongs to a wrong-path instruction.
REQ-021 SHALL, when the redirect condition holds, assert pc_redirect_en = 1 and flush = 1 combinationally for exactly that cycle, and return to IDLE at the next edge.
REQ-022 SHALL keep PENDING while the redirect condition is false, with pc_redirect_en = flush = 0 and pc_redirect_addr held.
REQ-023 SHALL ignore branch_en in PENDING, since it can only come from a wrong-path instruction.
REQ-024 SHALL have a latency from branch_en acceptance (cycle N) to the earliest redirect of N+1.
REQ-025 SHALL keep pc_redirect_en and flush at 0 in IDLE.
REQ-026 SHALL increment stall_cycles by 1 on each edge where the driven stall[0] = 1, saturating at 32'hFFFFFFFF.
REQ-027 SHALL increment flush_count by 1 on each edge where a redirect is issued, saturating at 32'hFFFFFFFF.
REQ-028 SHALL apply REQ-015 and REQ-019 on a redirect cycle with the same-cycle inputs, so stall = 6'b000111 on that cycle if stallreq_id = 0.

Reset
REQ-029 SHALL, when rst = 1 at an edge, set state = IDLE, pc_redirect_addr = 0, stall_cycles = 0 and flush_count = 0.
REQ-030 SHALL drive stall = 0, flush = 0 and pc_redirect_en = 0 in any cycle where rst = 1, regardless of the other inputs.
REQ-031 SHALL, on reset during PENDING, discard the pending redirect with no flush pulse.

Verification
REQ-032 Stall priority: stallreq_if = 1 and stallreq_mem = 1 together -> stall = 6'b011111; stallreq_if alone -> 6'b000011; all requests 0 -> 6'b000000.
REQ-033 Clean branch: branch_en = 1, branch_target = 32'h0000_1040, no stall requests at cycle N -> at N+1, pc_redirect_en = flush = 1, pc_redirect_addr = 32'h1040, stall = 6'b000111, flush_count = 1 after the edge.
REQ-034 Delayed redirect: branch accepted at N, stallreq_if = 1 for cycles N+1 to N+3 -> stall = 6'b000111 on N+1 to N+3, no flush; flush = 1 at N+4 only; stall_cycles increases by 4.
REQ-035 Branch during a MEM stall: branch_en = 1 with stallreq_mem = 1 -> no latch and state stays IDLE; the same branch_en after stallreq_mem drops -> accepted.
REQ-036 Reset mid-PENDING: branch accepted, then rst = 1 while stallreq_if = 1 -> after reset the state is IDLE, flush never pulses, counters read 0.
REQ-037 Saturation: preload stall_cycles near 32'hFFFFFFFF (force) and hold stallreq_if = 1 -> the counter stops at 32'hFFFFFFFF with no wrap.
